// File: rtl/multicycle_controller.sv
// multicycle_controller: multicycle MIPS control FSM with a memory-ready handshake
module multicycle_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       memready,
    output logic       iord,
    output logic       memwrite,
    output logic       memreq,
    output logic       irwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       regwrite,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [2:0] alucontrol,
    output logic       pcen,
    output logic       illegal,
    output logic [3:0] state
);
    localparam logic [3:0] FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMRD = 4'd3,
                           MEMWB = 4'd4, MEMWR = 4'd5, EXECUTE = 4'd6, ALUWB = 4'd7,
                           BEQ = 4'd8, ADDIEXEC = 4'd9, ADDIWB = 4'd10, JUMP = 4'd11;
    localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011,
                           OP_BEQ = 6'b000100, OP_ADDI = 6'b001000, OP_J = 6'b000010;
    logic [3:0] next;
    logic [1:0] aluop;
    logic       pcwrite, branch;
    // state register, active-low synchronous reset returns to FETCH
    always_ff @(posedge clk)
        if (!reset) state <= FETCH;
        else        state <= next;
    // next-state: memory states hold until memready, everything else advances
    always_comb begin
        next = FETCH;
        case (state)
            FETCH:    next = memready ? DECODE : FETCH;
            DECODE:   case (op)
                          OP_LW, OP_SW: next = MEMADR;
                          OP_R:         next = EXECUTE;
                          OP_BEQ:       next = BEQ;
                          OP_ADDI:      next = ADDIEXEC;
                          OP_J:         next = JUMP;
                          default:      next = FETCH;
                      endcase
            MEMADR:   next = (op == OP_LW) ? MEMRD : MEMWR;
            MEMRD:    next = memready ? MEMWB : MEMRD;
            MEMWR:    next = memready ? FETCH : MEMWR;
            EXECUTE:  next = ALUWB;
            ADDIEXEC: next = ADDIWB;
            default:  next = FETCH;
        endcase
    end
    // outputs: Moore decode of state, then ALU decode and write-enable gating under reset
    always_comb begin
        {iord, memwrite, memreq, irwrite, regdst, memtoreg, regwrite, alusrca} = '0;
        {alusrcb, pcsrc, aluop, pcwrite, branch, illegal} = '0;
        case (state)
            FETCH:    begin memreq = 1'b1; alusrcb = 2'b01; irwrite = memready; pcwrite = memready; end
            DECODE:   begin alusrcb = 2'b11; illegal = !(op inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J}); end
            MEMADR:   begin alusrca = 1'b1; alusrcb = 2'b10; end
            MEMRD:    begin memreq = 1'b1; iord = 1'b1; end
            MEMWB:    begin memtoreg = 1'b1; regwrite = 1'b1; end
            MEMWR:    begin memreq = 1'b1; iord = 1'b1; memwrite = 1'b1; end
            EXECUTE:  begin alusrca = 1'b1; aluop = 2'b10; end
            ALUWB:    begin regdst = 1'b1; regwrite = 1'b1; end
            BEQ:      begin alusrca = 1'b1; aluop = 2'b01; pcsrc = 2'b01; branch = 1'b1; end
            ADDIEXEC: begin alusrca = 1'b1; alusrcb = 2'b10; end
            ADDIWB:   regwrite = 1'b1;
            JUMP:     begin pcsrc = 2'b10; pcwrite = 1'b1; end
            default:  ;
        endcase
        case (aluop)
            2'b00:   alucontrol = 3'b010;
            2'b01:   alucontrol = 3'b110;
            default: case (funct)
                         6'b100010: alucontrol = 3'b110;
                         6'b100100: alucontrol = 3'b000;
                         6'b100101: alucontrol = 3'b001;
                         6'b101010: alucontrol = 3'b111;
                         default:   alucontrol = 3'b010;
                     endcase
        endcase
        alucontrol = (state > JUMP) ? 3'b000 : alucontrol;
        pcen = pcwrite | (branch & zero);
        if (!reset) {irwrite, pcen, regwrite, memwrite, memreq} = '0;
    end
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: cycle-by-cycle vector table plus CPI and reset corner sequences
module tb_multicycle_controller;
    localparam logic [5:0] R = 6'b000000, LW = 6'b100011, SW = 6'b101011,
                           BQ = 6'b000100, AI = 6'b001000, J = 6'b000010, BAD = 6'b111111;
    localparam logic [5:0] ADD = 6'b100000, SLT = 6'b101010, AND_ = 6'b100100;
    // {iord,memwrite,memreq,irwrite,regdst,memtoreg,regwrite,alusrca,alusrcb,pcsrc,alucontrol,pcen,illegal}
    localparam logic [16:0] O_FETCH   = 17'b0_0_1_1_0_0_0_0_01_00_010_1_0;
    localparam logic [16:0] O_FSTALL  = 17'b0_0_1_0_0_0_0_0_01_00_010_0_0;
    localparam logic [16:0] O_DEC     = 17'b0_0_0_0_0_0_0_0_11_00_010_0_0;
    localparam logic [16:0] O_DEC_ILL = 17'b0_0_0_0_0_0_0_0_11_00_010_0_1;
    localparam logic [16:0] O_MADR    = 17'b0_0_0_0_0_0_0_1_10_00_010_0_0;
    localparam logic [16:0] O_MRD     = 17'b1_0_1_0_0_0_0_0_00_00_010_0_0;
    localparam logic [16:0] O_MWB     = 17'b0_0_0_0_0_1_1_0_00_00_010_0_0;
    localparam logic [16:0] O_MWR     = 17'b1_1_1_0_0_0_0_0_00_00_010_0_0;
    localparam logic [16:0] O_EXE_ADD = 17'b0_0_0_0_0_0_0_1_00_00_010_0_0;
    localparam logic [16:0] O_EXE_SLT = 17'b0_0_0_0_0_0_0_1_00_00_111_0_0;
    localparam logic [16:0] O_EXE_AND = 17'b0_0_0_0_0_0_0_1_00_00_000_0_0;
    localparam logic [16:0] O_AWB     = 17'b0_0_0_0_1_0_1_0_00_00_010_0_0;
    localparam logic [16:0] O_BEQ_T   = 17'b0_0_0_0_0_0_0_1_00_01_110_1_0;
    localparam logic [16:0] O_BEQ_N   = 17'b0_0_0_0_0_0_0_1_00_01_110_0_0;
    localparam logic [16:0] O_AIE     = 17'b0_0_0_0_0_0_0_1_10_00_010_0_0;
    localparam logic [16:0] O_AIW     = 17'b0_0_0_0_0_0_1_0_00_00_010_0_0;
    localparam logic [16:0] O_JMP     = 17'b0_0_0_0_0_0_0_0_00_10_010_1_0;
    localparam logic [16:0] ALL       = 17'h1ffff;
    localparam logic [16:0] M_RST     = 17'b0_1_1_1_0_0_1_0_00_00_000_1_0;

    typedef struct packed {
        logic        rst;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic        z;
        logic        mr;
        logic [3:0]  st;
        logic [16:0] o;
        logic [16:0] m;
    } vec_t;

    logic clk = 1'b0, reset = 1'b0, zero = 1'b0, memready = 1'b1;
    logic [5:0] op = R, funct = ADD;
    logic iord, memwrite, memreq, irwrite, regdst, memtoreg, regwrite, alusrca, pcen, illegal;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] alucontrol;
    logic [3:0] state;
    logic [16:0] outs;
    vec_t vecs[$];
    int n_vec = 0, n_bad = 0;

    multicycle_controller dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .memready(memready),
        .iord(iord), .memwrite(memwrite), .memreq(memreq), .irwrite(irwrite), .regdst(regdst),
        .memtoreg(memtoreg), .regwrite(regwrite), .alusrca(alusrca), .alusrcb(alusrcb),
        .pcsrc(pcsrc), .alucontrol(alucontrol), .pcen(pcen), .illegal(illegal), .state(state)
    );

    assign outs = {iord, memwrite, memreq, irwrite, regdst, memtoreg, regwrite, alusrca,
                   alusrcb, pcsrc, alucontrol, pcen, illegal};

    always #5 clk = ~clk;

    task automatic v(input logic rst, input logic [5:0] o_, input logic [5:0] f_, input logic z_,
                     input logic mr_, input logic [3:0] st_, input logic [16:0] ex, input logic [16:0] mk);
        vecs.push_back('{rst, o_, f_, z_, mr_, st_, ex, mk});
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cpi(input string name, input logic [5:0] o_, input int want);
        int cycles = 0;
        op = o_;
        funct = ADD;
        zero = 1'b0;
        memready = 1'b1;
        do begin
            step();
            cycles++;
        end while (state != 4'd0 && cycles < 20);
        chk(name, cycles, want);
    endtask

    initial begin
        // R-type add through reset
        v(0, R, ADD, 0, 1, 0, 17'd0, M_RST);
        v(1, R, ADD, 0, 1, 0, O_FETCH, ALL);
        v(1, R, ADD, 0, 1, 1, O_DEC, ALL);
        v(1, R, ADD, 0, 1, 6, O_EXE_ADD, ALL);
        v(1, R, ADD, 0, 1, 7, O_AWB, ALL);
        // lw with fetch stall of 2 and MEMRD stall of 1
        v(1, LW, ADD, 0, 0, 0, O_FSTALL, ALL);
        v(1, LW, ADD, 0, 0, 0, O_FSTALL, ALL);
        v(1, LW, ADD, 0, 1, 0, O_FETCH, ALL);
        v(1, LW, ADD, 0, 1, 1, O_DEC, ALL);
        v(1, LW, ADD, 0, 1, 2, O_MADR, ALL);
        v(1, LW, ADD, 0, 0, 3, O_MRD, ALL);
        v(1, LW, ADD, 0, 1, 3, O_MRD, ALL);
        v(1, LW, ADD, 0, 1, 4, O_MWB, ALL);
        // sw with 3-cycle MEMWR stall
        v(1, SW, ADD, 0, 1, 0, O_FETCH, ALL);
        v(1, SW, ADD, 0, 1, 1, O_DEC, ALL);
        v(1, SW, ADD, 0, 1, 2, O_MADR, ALL);
        v(1, SW, ADD, 0, 0, 5, O_MWR, ALL);
        v(1, SW, ADD, 0, 0, 5, O_MWR, ALL);
        v(1, SW, ADD, 0, 0, 5, O_MWR, ALL);
        v(1, SW, ADD, 0, 1, 5, O_MWR, ALL);
        // beq taken then not taken
        v(1, BQ, ADD, 1, 1, 0, O_FETCH, ALL);
        v(1, BQ, ADD, 1, 1, 1, O_DEC, ALL);
        v(1, BQ, ADD, 1, 1, 8, O_BEQ_T, ALL);
        v(1, BQ, ADD, 0, 1, 0, O_FETCH, ALL);
        v(1, BQ, ADD, 0, 1, 1, O_DEC, ALL);
        v(1, BQ, ADD, 0, 1, 8, O_BEQ_N, ALL);
        // jump, illegal opcode, addi
        v(1, J, ADD, 0, 1, 0, O_FETCH, ALL);
        v(1, J, ADD, 0, 1, 1, O_DEC, ALL);
        v(1, J, ADD, 0, 1, 11, O_JMP, ALL);
        v(1, BAD, ADD, 0, 1, 0, O_FETCH, ALL);
        v(1, BAD, ADD, 0, 1, 1, O_DEC_ILL, ALL);
        v(1, AI, ADD, 0, 1, 0, O_FETCH, ALL);
        v(1, AI, ADD, 0, 1, 1, O_DEC, ALL);
        v(1, AI, ADD, 0, 1, 9, O_AIE, ALL);
        v(1, AI, ADD, 0, 1, 10, O_AIW, ALL);
        // reset during stalled store, then slt and and
        v(1, SW, ADD, 0, 1, 0, O_FETCH, ALL);
        v(1, SW, ADD, 0, 1, 1, O_DEC, ALL);
        v(1, SW, ADD, 0, 1, 2, O_MADR, ALL);
        v(1, SW, ADD, 0, 0, 5, O_MWR, ALL);
        v(0, SW, ADD, 0, 0, 5, 17'd0, M_RST);
        v(1, R, SLT, 0, 1, 0, O_FETCH, ALL);
        v(1, R, SLT, 0, 1, 1, O_DEC, ALL);
        v(1, R, SLT, 0, 1, 6, O_EXE_SLT, ALL);
        v(1, R, SLT, 0, 1, 7, O_AWB, ALL);
        v(1, R, AND_, 0, 1, 0, O_FETCH, ALL);
        v(1, R, AND_, 0, 1, 1, O_DEC, ALL);
        v(1, R, AND_, 0, 1, 6, O_EXE_AND, ALL);
        v(1, R, AND_, 0, 1, 7, O_AWB, ALL);

        step();
        foreach (vecs[i]) begin
            reset = vecs[i].rst;
            op = vecs[i].op;
            funct = vecs[i].fn;
            zero = vecs[i].z;
            memready = vecs[i].mr;
            #1;
            chk($sformatf("row%0d state", i), 32'(state), 32'(vecs[i].st));
            chk($sformatf("row%0d outs", i), 32'(outs & vecs[i].m), 32'(vecs[i].o & vecs[i].m));
            step();
        end

        cpi("cpi lw", LW, 5);
        cpi("cpi sw", SW, 4);
        cpi("cpi R", R, 4);
        cpi("cpi addi", AI, 4);
        cpi("cpi beq", BQ, 3);
        cpi("cpi j", J, 3);

        op = LW;
        memready = 1'b1;
        step();
        step();
        memready = 1'b0;
        step();
        step();
        chk("memrd stall hold", 32'(state), 32'd3);
        reset = 1'b0;
        #1;
        chk("reset in memrd enables", 32'({regwrite, memwrite, memreq, irwrite, pcen}), 32'd0);
        step();
        chk("reset in memrd state", 32'(state), 32'd0);
        reset = 1'b1;
        memready = 1'b1;
        step();
        chk("fetch after reset", 32'(state), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
